// File: rtl/alu_stack_feeder.sv
// ---------------------------------------------------------------------------
// alu_stack_feeder
//
// Operand stage that sits in front of a 16-bit combinational ALU running in
// stack mode. It keeps a LIFO of DEPTH 16-bit operands and takes commands
// over a valid/ready handshake:
//   PUSH   - store cmd_data on top of the stack (single cycle)
//   POP    - remove the top entry and present it on pop_data (single cycle)
//   UNARY  - top -> ALU -> replaces top
//   BINARY - (second, top) -> ALU -> replaces both with one result
// Arithmetic commands run IDLE -> OPRD -> WB. Operands are registered on
// accept, the ALU settles during OPRD, and the result is written back on the
// OPRD -> WB edge together with the latched n/z/p flags.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake (ready only in IDLE)
//   cmd_type            00 PUSH, 01 POP, 10 UNARY, 11 BINARY
//   cmd_data            PUSH operand
//   cmd_aluop           ALU opcode for UNARY/BINARY
//   alu_op/alu_a/alu_b  registered opcode/operands to the ALU (op 1111 = hold)
//   alu_res, alu_n/z/p  ALU result and flags
//   pop_valid/pop_data  one-cycle pulse carrying the popped value
//   nzp                 {n,z,p} of the last written-back result
//   depth               current number of stack entries
//   err_ovf/err_udf     sticky overflow / underflow-or-illegal-opcode flags
//   err_clr             synchronous clear of both sticky flags (wins over set)
// ---------------------------------------------------------------------------
module alu_stack_feeder #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [15:0]      cmd_data,
    input  logic [3:0]       cmd_aluop,
    output logic [3:0]       alu_op,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    input  logic [15:0]      alu_res,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_p,
    output logic             pop_valid,
    output logic [15:0]      pop_data,
    output logic [2:0]       nzp,
    output logic [PTR_W-1:0] depth,
    output logic             err_ovf,
    output logic             err_udf,
    input  logic             err_clr
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] CMD_PUSH   = 2'b00;
    localparam logic [1:0] CMD_POP    = 2'b01;
    localparam logic [1:0] CMD_UNARY  = 2'b10;
    localparam logic [1:0] CMD_BINARY = 2'b11;

    localparam logic [3:0] OP_HOLD = 4'b1111;

    // One bit per opcode value: set where that opcode is legal for the
    // command class. Unary: 1, 7, 8. Binary: 0, 2, 3, 4, 5, 6.
    localparam logic [15:0] UNARY_MASK  = 16'h0182;
    localparam logic [15:0] BINARY_MASK = 16'h007D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OPRD = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [PTR_W-1:0] depth_reg, depth_next;
    logic [3:0]       alu_op_reg;
    logic [15:0]      alu_a_reg;
    logic [15:0]      alu_b_reg;
    logic             pop_valid_reg;
    logic [15:0]      pop_data_reg;
    logic [2:0]       nzp_reg;
    logic             err_ovf_reg;
    logic             err_udf_reg;
    logic             binary_reg;   // operation in flight is BINARY

    // -----------------------------------------------------------------------
    // Stack storage (no reset: contents are meaningless while depth is 0)
    // -----------------------------------------------------------------------
    logic [15:0]      stack_mem [DEPTH];
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [15:0]      wr_data;

    // Index arithmetic is done in IDX_W bits; with DEPTH a power of two the
    // wrap from depth==DEPTH (low bits all zero) lands on the right entry.
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] sec_idx;
    logic [15:0]      top_val;
    logic [15:0]      sec_val;

    assign push_idx = depth_reg[IDX_W-1:0];
    assign top_idx  = depth_reg[IDX_W-1:0] - IDX_W'(1);
    assign sec_idx  = depth_reg[IDX_W-1:0] - IDX_W'(2);
    assign top_val  = stack_mem[top_idx];
    assign sec_val  = stack_mem[sec_idx];

    // -----------------------------------------------------------------------
    // Command decode
    // -----------------------------------------------------------------------
    logic accept;
    logic has_one;
    logic has_two;
    logic is_full;
    logic unary_legal;
    logic binary_legal;
    logic do_push;
    logic do_pop;
    logic do_unary;
    logic do_binary;
    logic start_op;
    logic wb_en;
    logic ovf_set;
    logic udf_set;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    assign has_one = (depth_reg != '0);
    assign has_two = (depth_reg >= PTR_W'(2));
    assign is_full = (depth_reg == PTR_W'(DEPTH));

    assign unary_legal  = UNARY_MASK[cmd_aluop];
    assign binary_legal = BINARY_MASK[cmd_aluop];

    always_comb begin
        do_push   = 1'b0;
        do_pop    = 1'b0;
        do_unary  = 1'b0;
        do_binary = 1'b0;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        if (accept) begin
            case (cmd_type)
                CMD_PUSH: begin
                    do_push = ~is_full;
                    ovf_set = is_full;
                end
                CMD_POP: begin
                    do_pop  = has_one;
                    udf_set = ~has_one;
                end
                CMD_UNARY: begin
                    do_unary = unary_legal & has_one;
                    udf_set  = ~(unary_legal & has_one);
                end
                CMD_BINARY: begin
                    do_binary = binary_legal & has_two;
                    udf_set   = ~(binary_legal & has_two);
                end
                default: ;
            endcase
        end
    end

    assign start_op = do_unary | do_binary;
    // Writeback happens on the edge that leaves OPRD; a reset during OPRD
    // forces IDLE asynchronously, so the write never occurs.
    assign wb_en    = (state_reg == ST_OPRD);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_op) state_next = ST_OPRD;
            ST_OPRD: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Stack write port and depth update
    // -----------------------------------------------------------------------
    always_comb begin
        wr_en      = 1'b0;
        wr_idx     = push_idx;
        wr_data    = cmd_data;
        depth_next = depth_reg;
        if (do_push) begin
            wr_en      = 1'b1;
            depth_next = depth_reg + PTR_W'(1);
        end else if (do_pop) begin
            depth_next = depth_reg - PTR_W'(1);
        end else if (wb_en) begin
            wr_en   = 1'b1;
            wr_data = alu_res;
            if (binary_reg) begin
                wr_idx     = sec_idx;
                depth_next = depth_reg - PTR_W'(1);
            end else begin
                wr_idx = top_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_mem[wr_idx] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_reg     <= '0;
            alu_op_reg    <= OP_HOLD;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            pop_valid_reg <= 1'b0;
            pop_data_reg  <= '0;
            nzp_reg       <= 3'b010;
            err_ovf_reg   <= 1'b0;
            err_udf_reg   <= 1'b0;
            binary_reg    <= 1'b0;
        end else begin
            depth_reg     <= depth_next;
            pop_valid_reg <= do_pop;
            if (do_pop) begin
                pop_data_reg <= top_val;
            end

            if (start_op) begin
                alu_op_reg <= cmd_aluop;
                binary_reg <= do_binary;
                alu_a_reg  <= do_binary ? sec_val : top_val;
                alu_b_reg  <= do_binary ? top_val : 16'h0000;
            end else if (wb_en) begin
                alu_op_reg <= OP_HOLD;
            end

            if (wb_en) begin
                nzp_reg <= {alu_n, alu_z, alu_p};
            end

            if (err_clr) begin
                err_ovf_reg <= 1'b0;
                err_udf_reg <= 1'b0;
            end else begin
                if (ovf_set) err_ovf_reg <= 1'b1;
                if (udf_set) err_udf_reg <= 1'b1;
            end
        end
    end

    assign alu_op    = alu_op_reg;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign pop_valid = pop_valid_reg;
    assign pop_data  = pop_data_reg;
    assign nzp       = nzp_reg;
    assign depth     = depth_reg;
    assign err_ovf   = err_ovf_reg;
    assign err_udf   = err_udf_reg;

endmodule
